// File: rtl/alu_pkg.sv
// Shared opcode and handshake-state encodings for the alu_hs ALU.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_SRA = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative signed multiplier: radix-2 shift-add on operand magnitudes,
// sign applied to the final product. One iteration per enabled edge.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic               busy_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [RES_W:0]     prod_q;
  logic [RES_W:0]     prod_d;
  logic [WIDTH:0]     hi_sum;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [RES_W-1:0]   mag;

  // Magnitudes are unsigned, so the most negative operand needs no special case.
  always_comb begin
    mag_a     = a_i[WIDTH-1] ? WIDTH'(-a_i) : a_i;
    mag_b     = b_i[WIDTH-1] ? WIDTH'(-b_i) : b_i;
    hi_sum    = prod_q[RES_W:WIDTH] + {1'b0, mcand_q & {WIDTH{prod_q[0]}}};
    prod_d    = {1'b0, hi_sum, prod_q[WIDTH-1:1]};
    mag       = prod_d[RES_W-1:0];
    product_c = neg_q ? RES_W'(-mag) : mag;
  end

  // Valid only on the final iteration edge, where product_c is the finished result.
  assign done_c = enable & busy_q & (cnt_q == CNT_W'(WIDTH - 1));
  assign busy_o = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (enable) begin
      if (start_i) begin
        busy_q  <= 1'b1;
        neg_q   <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
        cnt_q   <= '0;
        mcand_q <= mag_a;
        prod_q  <= {{(WIDTH + 1){1'b0}}, mag_b};
      end else if (busy_q) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/alu_hs.sv
// Signed ALU with valid/ready handshakes: single-cycle ops plus iterative MUL.
// Results are sign-extended to 2*WIDTH and held until the consumer takes them.
module alu_hs
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           opcode,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 zero,
  output logic                 ovf
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned EXT_W = RES_W - WIDTH;

  state_e             state_q;
  logic [RES_W-1:0]   out_q;
  logic               zero_q;
  logic               ovf_q;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_ovf;
  logic [RES_W-1:0]   mul_prod;

  logic [WIDTH:0]     sum_d;
  logic [WIDTH-1:0]   logic_d;
  logic [RES_W-1:0]   res_d;
  logic               ovf_d;

  assign out_valid = (state_q == S_HOLD);
  assign in_ready  = enable & (state_q != S_BUSY) & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (opcode == OP_MUL);

  // Single-cycle datapath; ADD/SUB use a WIDTH+1 exact sum for the overflow check.
  always_comb begin
    sum_d   = '0;
    logic_d = '0;
    res_d   = '0;
    ovf_d   = 1'b0;
    case (opcode)
      OP_ADD:  sum_d   = {in0[WIDTH-1], in0} + {in1[WIDTH-1], in1};
      OP_SUB:  sum_d   = {in0[WIDTH-1], in0} - {in1[WIDTH-1], in1};
      OP_AND:  logic_d = in0 & in1;
      OP_OR:   logic_d = in0 | in1;
      OP_XOR:  logic_d = in0 ^ in1;
      OP_SLT:  logic_d = WIDTH'($signed(in0) < $signed(in1));
      OP_SRA:  logic_d = $signed(in0) >>> in1[SH_W-1:0];
      default: logic_d = '0;
    endcase
    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
      res_d = {{(EXT_W - 1){sum_d[WIDTH]}}, sum_d};
      ovf_d = sum_d[WIDTH] ^ sum_d[WIDTH-1];
    end else begin
      res_d = {{EXT_W{logic_d[WIDTH-1]}}, logic_d};
    end
  end

  // Product fits in signed WIDTH only if its top WIDTH+1 bits are all equal.
  assign mul_ovf = ~((&mul_prod[RES_W-1:WIDTH-1]) | ~(|mul_prod[RES_W-1:WIDTH-1]));

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .start_i   (mul_start),
    .a_i       (in0),
    .b_i       (in1),
    .busy_o    (mul_busy),
    .done_c    (mul_done),
    .product_c (mul_prod)
  );

  // Handshake FSM and result registers; an accept in HOLD implies a same-edge transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (enable) begin
      unique case (state_q)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              state_q <= S_BUSY;
            end else begin
              state_q <= S_HOLD;
              out_q   <= res_d;
              zero_q  <= (res_d == '0);
              ovf_q   <= ovf_d;
            end
          end else if (out_valid && out_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (mul_done) begin
            state_q <= S_HOLD;
            out_q   <= mul_prod;
            zero_q  <= (mul_prod == '0);
            ovf_q   <= mul_ovf;
          end else if (!mul_busy) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule
